mock_alu_iterative_shifter: RTL and testbench

// - Multi-cycle shift unit for the mock ALU. Shifts by at most STEP bits per cycle instead of a full barrel network.
// - Sits between the ALU issue stage (request side) and writeback (response side).
// - Uses valid/ready handshakes on both sides. Area-lean counterpart of the single-cycle shifter.
// - Same opcode and result semantics as the single-cycle shifter: a result can be cross-checked bit-for-bit.

---
 rtl/mock_alu_pkg.sv | 15 +
 rtl/mock_alu_shift_step.sv | 33 +++
 rtl/mock_alu_iterative_shifter.sv | 103 ++++++++++
 tb/tb_mock_alu_iterative_shifter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mock_alu_pkg.sv
// rtl/mock_alu_pkg.sv - shift opcodes and FSM state type for the iterative shifter
package mock_alu_pkg;

  localparam logic [5:0] OP_SLL = 6'hB;
  localparam logic [5:0] OP_SRL = 6'hC;
  localparam logic [5:0] OP_SRA = 6'hD;
  localparam logic [5:0] OP_ROR = 6'hE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mock_alu_shift_step.sv
// rtl/mock_alu_shift_step.sv - combinational shift of 0..STEP bits per the latched opcode
// Rotate logic exists only when MOCK_ALU_ROTATE_EN is defined; otherwise 0xE decodes as SRL.
module mock_alu_shift_step
  import mock_alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int STEP  = 8
) (
  input  logic [WIDTH-1:0]             data,
  input  logic [5:0]                   op,
  input  logic [$clog2(STEP+1)-1:0]    amt,
  output logic [WIDTH-1:0]             result
);

`ifdef MOCK_ALU_ROTATE_EN
  logic [6:0] back_amt;
  always_comb back_amt = 7'(WIDTH) - 7'(amt);
`endif

  // SRA uses the current value's MSB, which always equals the latched operand's bit 63
  always_comb begin
    result = data >> amt;
    case (op)
      OP_SLL: result = data << amt;
      OP_SRA: result = WIDTH'($signed(data) >>> amt);
`ifdef MOCK_ALU_ROTATE_EN
      OP_ROR: result = (data >> amt) | (data << back_amt);
`endif
      default: result = data >> amt;
    endcase
  end

endmodule

// File: rtl/mock_alu_iterative_shifter.sv
// rtl/mock_alu_iterative_shifter.sv - multi-cycle shifter, at most STEP bits per cycle
// Optional rotate-right on opcode 0xE via MOCK_ALU_ROTATE_EN.
module mock_alu_iterative_shifter
  import mock_alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int STEP  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_data,
  input  logic [5:0]       io_in_shiftAmount,
  input  logic [5:0]       io_in_dir,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits,
  output logic             io_busy
);

  localparam int AW = $clog2(STEP + 1);

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] step_out;
  logic [5:0]       op_q;
  logic [6:0]       rem_q;
  logic [6:0]       step_amt;
  logic [AW-1:0]    step_amt_n;

  always_comb begin
    step_amt   = (rem_q < 7'(STEP)) ? rem_q : 7'(STEP);
    step_amt_n = AW'(step_amt);
  end

  mock_alu_shift_step #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_step (
    .data  (data_q),
    .op    (op_q),
    .amt   (step_amt_n),
    .result(step_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      io_in_ready  <= 1'b1;
      io_out_valid <= 1'b0;
      io_out_bits  <= '0;
      io_busy      <= 1'b0;
      data_q       <= '0;
      op_q         <= '0;
      rem_q        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io_in_valid && io_in_ready) begin
            data_q      <= io_in_data;
            op_q        <= io_in_dir;
            rem_q       <= {1'b0, io_in_shiftAmount};
            io_in_ready <= 1'b0;
            io_busy     <= 1'b1;
            if (io_in_shiftAmount == 6'd0) begin
              state        <= ST_DONE;
              io_out_valid <= 1'b1;
              io_out_bits  <= io_in_data;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          data_q <= step_out;
          rem_q  <= rem_q - step_amt;
          if (rem_q == step_amt) begin
            state        <= ST_DONE;
            io_out_valid <= 1'b1;
            io_out_bits  <= step_out;
          end
        end
        ST_DONE: begin
          // Input side stays closed even in the handshake cycle; it reopens from IDLE
          if (io_out_ready) begin
            state        <= ST_IDLE;
            io_out_valid <= 1'b0;
            io_in_ready  <= 1'b1;
            io_busy      <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          io_in_ready  <= 1'b1;
          io_out_valid <= 1'b0;
          io_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mock_alu_iterative_shifter.sv
// tb/tb_mock_alu_iterative_shifter.sv - scoreboard bench for the iterative shifter
module tb_mock_alu_iterative_shifter;

  localparam int STEP = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [63:0] io_in_data;
  logic [5:0]  io_in_shiftAmount;
  logic [5:0]  io_in_dir;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [63:0] io_out_bits;
  logic        io_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [63:0] sb_q[$];
  int          lat_q[$];

  mock_alu_iterative_shifter #(.WIDTH(64), .STEP(STEP)) dut (
    .clock            (clock),
    .reset            (reset),
    .io_in_valid      (io_in_valid),
    .io_in_ready      (io_in_ready),
    .io_in_data       (io_in_data),
    .io_in_shiftAmount(io_in_shiftAmount),
    .io_in_dir        (io_in_dir),
    .io_out_valid     (io_out_valid),
    .io_out_ready     (io_out_ready),
    .io_out_bits      (io_out_bits),
    .io_busy          (io_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [63:0] d, input int amt, input logic [5:0] dir);
    case (dir)
      6'hB: return d << amt;
      6'hD: return 64'($signed(d) >>> amt);
`ifdef MOCK_ALU_ROTATE_EN
      6'hE: return (d >> amt) | (d << (64 - amt));
`endif
      default: return d >> amt;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic run_op(input logic [63:0] d, input int amt, input logic [5:0] dir, input int hold);
    int lat;
    logic [63:0] exp;
    int exp_lat;
    @(negedge clock);
    check("in_ready_idle", 64'(io_in_ready), 64'd1);
    io_in_valid       = 1'b1;
    io_in_data        = d;
    io_in_shiftAmount = 6'(amt);
    io_in_dir         = dir;
    sb_q.push_back(model(d, amt, dir));
    lat_q.push_back(1 + (amt + STEP - 1) / STEP);
    @(posedge clock);
    #1;
    io_in_valid       = 1'b0;
    io_in_data        = {$urandom, $urandom};
    io_in_shiftAmount = 6'($urandom);
    io_in_dir         = 6'($urandom);
    lat = 1;
    @(negedge clock);
    while (!io_out_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    exp_lat = lat_q.pop_front();
    exp     = sb_q.pop_front();
    check("latency", 64'(lat), 64'(exp_lat));
    check("result", io_out_bits, exp);
    check("in_ready_done", 64'(io_in_ready), 64'd0);
    check("busy_done", 64'(io_busy), 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("held_bits", io_out_bits, exp);
      check("held_valid", 64'(io_out_valid), 64'd1);
      check("held_in_ready", 64'(io_in_ready), 64'd0);
    end
    io_out_ready = 1'b1;
    @(negedge clock);
    io_out_ready = 1'b0;
    check("idle_valid", 64'(io_out_valid), 64'd0);
    check("idle_in_ready", 64'(io_in_ready), 64'd1);
    check("idle_busy", 64'(io_busy), 64'd0);
    check("idle_bits_kept", io_out_bits, exp);
  endtask

  initial begin
    int rises;
    logic [5:0] dirs[5];
    dirs = '{6'hB, 6'hC, 6'hD, 6'hE, 6'h3};
    reset             = 1'b1;
    io_in_valid       = 1'b0;
    io_in_data        = '0;
    io_in_shiftAmount = '0;
    io_in_dir         = '0;
    io_out_ready      = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_in_ready", 64'(io_in_ready), 64'd1);
    check("rst_out_valid", 64'(io_out_valid), 64'd0);
    check("rst_out_bits", io_out_bits, 64'd0);
    check("rst_busy", 64'(io_busy), 64'd0);

    run_op(64'h1, 63, 6'hB, 0);
    run_op(64'h8000_0000_0000_0000, 4, 6'hD, 0);
    run_op(64'hDEAD_BEEF, 0, 6'hC, 0);
    run_op(64'hFF00, 8, 6'h3, 0);
    run_op(64'h1234_5678_9ABC_DEF0, 9, 6'hC, 5);
    run_op(64'h1, 1, 6'hE, 0);
    run_op(64'hF000_0000_0000_0001, 16, 6'hE, 0);
    run_op(64'hC000_0000_0000_0000, 63, 6'hD, 0);

    // Reset while the op is mid-flight: no result may ever appear
    @(negedge clock);
    io_in_valid       = 1'b1;
    io_in_data        = 64'hFFFF_0000_FFFF_0000;
    io_in_shiftAmount = 6'd40;
    io_in_dir         = 6'hC;
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst2_in_ready", 64'(io_in_ready), 64'd1);
    check("rst2_busy", 64'(io_busy), 64'd0);
    check("rst2_bits", io_out_bits, 64'd0);
    rises = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (io_out_valid) rises++;
    end
    check("rst2_no_result", 64'(rises), 64'd0);
    run_op(64'hF0, 4, 6'hC, 0);

    for (int i = 0; i < 12; i++) begin
      run_op({$urandom, $urandom}, int'($urandom_range(0, 63)), dirs[$urandom_range(0, 4)],
             int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
